// File: rtl/qed_pkg.sv
// Shared definitions for the QED front end: window state encoding and the
// window depth that the decoder, i-cache and duplication controller agree on.
package qed_pkg;

    typedef enum logic [2:0] {
        QS_IDLE  = 3'd0,
        QS_ORIG  = 3'd1,
        QS_DUP   = 3'd2,
        QS_DRAIN = 3'd3,
        QS_DONE  = 3'd4
    } qed_state_e;

    localparam int QED_DEPTH     = 8;
    localparam int QED_DRAIN_CYC = 5;

    function automatic int qedCntWidth(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/qed_drain_timer.sv
// Counts the pipeline drain after the last duplicate; expire_o is high in the
// cycle whose closing edge brings the count to DRAIN_CYC.
module qed_drain_timer
    import qed_pkg::*;
#(
    parameter int DRAIN_CYC = QED_DRAIN_CYC,
    parameter int TW        = $clog2(DRAIN_CYC + 1)
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic start_i,
    input  logic clear_i,
    output logic expire_o
);

    logic          run_q, run_d;
    logic [TW-1:0] cnt_q, cnt_d;

    always_comb begin
        run_d = run_q;
        cnt_d = cnt_q;
        if (clear_i) begin
            run_d = 1'b0;
            cnt_d = '0;
        end else if (start_i) begin
            run_d = 1'b1;
            cnt_d = '0;
        end else if (run_q) begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_d == TW'(DRAIN_CYC)) begin
                run_d = 1'b0;
            end
        end
    end

    assign expire_o = run_q && (cnt_q == TW'(DRAIN_CYC - 1));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            run_q <= 1'b0;
            cnt_q <= '0;
        end else begin
            run_q <= run_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/qed_dup_ctrl.sv
// QED duplication controller: counts originals, replays the same number of
// duplicates, waits for the pipeline to drain, then flags the window for checking.
module qed_dup_ctrl
    import qed_pkg::*;
#(
    parameter int DEPTH     = QED_DEPTH,
    parameter int CNT_W     = qedCntWidth(DEPTH),
    parameter int DRAIN_CYC = QED_DRAIN_CYC
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             ena_i,
    input  logic             stall_IF_i,
    input  logic             fetch_vld_i,
    input  logic             dup_vld_i,
    input  logic             force_dup_i,
    output logic             exec_dup_o,
    output logic [CNT_W-1:0] orig_cnt_o,
    output logic [CNT_W-1:0] dup_cnt_o,
    output logic             qed_check_o,
    output logic             qed_done_o
);

    localparam logic [CNT_W-1:0] DepthCnt = CNT_W'(DEPTH);

    qed_state_e       state_q, state_d;
    logic [CNT_W-1:0] origCnt_q, origCnt_d;
    logic [CNT_W-1:0] dupCnt_q, dupCnt_d;
    logic             execDup_q, qedCheck_q, qedDone_q;
    logic             acceptOrig, acceptDup;
    logic             timerStart, timerClear, timerExpire;

    assign acceptOrig = fetch_vld_i & ~stall_IF_i;
    assign acceptDup  = dup_vld_i & ~stall_IF_i;

    // Dropping ena wins over everything, including a drain that expires this cycle.
    always_comb begin
        state_d    = state_q;
        origCnt_d  = origCnt_q;
        dupCnt_d   = dupCnt_q;
        timerStart = 1'b0;
        timerClear = 1'b0;
        if (!ena_i) begin
            state_d    = QS_IDLE;
            origCnt_d  = '0;
            dupCnt_d   = '0;
            timerClear = 1'b1;
        end else begin
            case (state_q)
                QS_IDLE: begin
                    state_d   = QS_ORIG;
                    origCnt_d = '0;
                    dupCnt_d  = '0;
                end
                QS_ORIG: begin
                    if (acceptOrig && (origCnt_q != DepthCnt)) begin
                        origCnt_d = origCnt_q + CNT_W'(1);
                    end
                    if (!stall_IF_i &&
                        ((origCnt_d == DepthCnt) || (force_dup_i && (origCnt_d != '0)))) begin
                        state_d = QS_DUP;
                    end
                end
                QS_DUP: begin
                    if (acceptDup && (dupCnt_q != origCnt_q)) begin
                        dupCnt_d = dupCnt_q + CNT_W'(1);
                    end
                    if (dupCnt_d == origCnt_q) begin
                        state_d    = QS_DRAIN;
                        timerStart = 1'b1;
                    end
                end
                QS_DRAIN: begin
                    if (timerExpire) begin
                        state_d = QS_DONE;
                    end
                end
                QS_DONE: begin
                    state_d = QS_DONE;
                end
                default: begin
                    state_d    = QS_IDLE;
                    origCnt_d  = '0;
                    dupCnt_d   = '0;
                    timerClear = 1'b1;
                end
            endcase
        end
    end

    qed_drain_timer #(
        .DRAIN_CYC (DRAIN_CYC)
    ) u_drain_timer (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .start_i  (timerStart),
        .clear_i  (timerClear),
        .expire_o (timerExpire)
    );

    // Outputs are decoded from the next state so they change on the same edge as the FSM.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= QS_IDLE;
            origCnt_q  <= '0;
            dupCnt_q   <= '0;
            execDup_q  <= 1'b0;
            qedCheck_q <= 1'b0;
            qedDone_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            origCnt_q  <= origCnt_d;
            dupCnt_q   <= dupCnt_d;
            execDup_q  <= (state_d == QS_DUP);
            qedCheck_q <= (state_q == QS_DRAIN) && (state_d == QS_DONE);
            qedDone_q  <= (state_d == QS_DONE);
        end
    end

    assign exec_dup_o  = execDup_q;
    assign orig_cnt_o  = origCnt_q;
    assign dup_cnt_o   = dupCnt_q;
    assign qed_check_o = qedCheck_q;
    assign qed_done_o  = qedDone_q;

endmodule

// File: tb/tb_qed_dup_ctrl.sv
// Directed bench for qed_dup_ctrl: reset, full window, forced switch, stall,
// ena drop during drain, asynchronous reset and duplicate saturation.
module tb_qed_dup_ctrl;

    logic       clk = 1'b0;
    logic       rstN;
    logic       ena;
    logic       stallIf;
    logic       fetchVld;
    logic       dupVld;
    logic       forceDup;
    logic       execDup;
    logic [3:0] origCnt;
    logic [3:0] dupCnt;
    logic       qedCheck;
    logic       qedDone;

    int errors = 0;
    int checks = 0;

    qed_dup_ctrl dut (
        .clk_i       (clk),
        .rst_ni      (rstN),
        .ena_i       (ena),
        .stall_IF_i  (stallIf),
        .fetch_vld_i (fetchVld),
        .dup_vld_i   (dupVld),
        .force_dup_i (forceDup),
        .exec_dup_o  (execDup),
        .orig_cnt_o  (origCnt),
        .dup_cnt_o   (dupCnt),
        .qed_check_o (qedCheck),
        .qed_done_o  (qedDone)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic applyStimulus(input logic e, input logic s, input logic f,
                                 input logic d, input logic fd);
        ena      = e;
        stallIf  = s;
        fetchVld = f;
        dupVld   = d;
        forceDup = fd;
    endtask

    // Leaves the DUT in ORIG with both counters at zero.
    task automatic startWindow;
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick(1);
        ena = 1'b1;
        tick(1);
    endtask

    task automatic test_reset;
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        rstN = 1'b0;
        tick(3);
        checks++;
        if (execDup !== 1'b0 || qedCheck !== 1'b0 || qedDone !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_flags: exec=%b check=%b done=%b required 0 0 0",
                     execDup, qedCheck, qedDone);
        end
        checks++;
        if (origCnt !== 4'd0 || dupCnt !== 4'd0) begin
            errors++;
            $display("[TB] FAIL reset_counts: orig=%0d dup=%0d required 0 0", origCnt, dupCnt);
        end
        rstN = 1'b1;
        tick(1);
        checks++;
        if (origCnt !== 4'd0) begin
            errors++;
            $display("[TB] FAIL reset_idle_no_count: orig=%0d required 0", origCnt);
        end
        tick(1);
        checks++;
        if (origCnt !== 4'd1) begin
            errors++;
            $display("[TB] FAIL reset_first_count: orig=%0d required 1", origCnt);
        end
        tick(1);
        checks++;
        if (origCnt !== 4'd2) begin
            errors++;
            $display("[TB] FAIL reset_second_count: orig=%0d required 2", origCnt);
        end
    endtask

    task automatic test_full_window;
        startWindow();
        fetchVld = 1'b1;
        tick(7);
        checks++;
        if (origCnt !== 4'd7 || execDup !== 1'b0) begin
            errors++;
            $display("[TB] FAIL full_seven: orig=%0d exec=%b required 7 0", origCnt, execDup);
        end
        tick(1);
        checks++;
        if (origCnt !== 4'd8 || execDup !== 1'b1) begin
            errors++;
            $display("[TB] FAIL full_switch: orig=%0d exec=%b required 8 1", origCnt, execDup);
        end
        dupVld = 1'b1;
        tick(7);
        checks++;
        if (origCnt !== 4'd8 || dupCnt !== 4'd7 || execDup !== 1'b1) begin
            errors++;
            $display("[TB] FAIL full_dup_seven: orig=%0d dup=%0d exec=%b required 8 7 1",
                     origCnt, dupCnt, execDup);
        end
        tick(1);
        checks++;
        if (dupCnt !== 4'd8 || execDup !== 1'b0) begin
            errors++;
            $display("[TB] FAIL full_drain_entry: dup=%0d exec=%b required 8 0", dupCnt, execDup);
        end
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        tick(4);
        checks++;
        if (qedCheck !== 1'b0 || qedDone !== 1'b0) begin
            errors++;
            $display("[TB] FAIL full_drain_early: check=%b done=%b required 0 0", qedCheck, qedDone);
        end
        tick(1);
        checks++;
        if (qedCheck !== 1'b1 || qedDone !== 1'b1) begin
            errors++;
            $display("[TB] FAIL full_check_pulse: check=%b done=%b required 1 1", qedCheck, qedDone);
        end
        tick(1);
        checks++;
        if (qedCheck !== 1'b0 || qedDone !== 1'b1 || origCnt !== 4'd8 || dupCnt !== 4'd8) begin
            errors++;
            $display("[TB] FAIL full_done_hold: check=%b done=%b orig=%0d dup=%0d required 0 1 8 8",
                     qedCheck, qedDone, origCnt, dupCnt);
        end
    endtask

    task automatic test_force_dup;
        startWindow();
        fetchVld = 1'b1;
        tick(3);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        tick(1);
        checks++;
        if (execDup !== 1'b1 || origCnt !== 4'd3) begin
            errors++;
            $display("[TB] FAIL force_switch: exec=%b orig=%0d required 1 3", execDup, origCnt);
        end
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        tick(2);
        checks++;
        if (execDup !== 1'b1 || dupCnt !== 4'd2) begin
            errors++;
            $display("[TB] FAIL force_dup_two: exec=%b dup=%0d required 1 2", execDup, dupCnt);
        end
        tick(1);
        checks++;
        if (execDup !== 1'b0 || dupCnt !== 4'd3) begin
            errors++;
            $display("[TB] FAIL force_drain: exec=%b dup=%0d required 0 3", execDup, dupCnt);
        end
        dupVld = 1'b0;
        tick(5);
        checks++;
        if (qedCheck !== 1'b1 || origCnt !== 4'd3 || dupCnt !== 4'd3) begin
            errors++;
            $display("[TB] FAIL force_check: check=%b orig=%0d dup=%0d required 1 3 3",
                     qedCheck, origCnt, dupCnt);
        end
        startWindow();
        forceDup = 1'b1;
        tick(2);
        checks++;
        if (execDup !== 1'b0 || origCnt !== 4'd0) begin
            errors++;
            $display("[TB] FAIL force_at_zero: exec=%b orig=%0d required 0 0", execDup, origCnt);
        end
    endtask

    task automatic test_stall;
        int bad;
        startWindow();
        fetchVld = 1'b1;
        tick(7);
        stallIf = 1'b1;
        bad = 0;
        for (int i = 0; i < 3; i++) begin
            tick(1);
            if (execDup !== 1'b0 || origCnt !== 4'd7) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("[TB] FAIL stall_hold: exec=%b orig=%0d required 0 7 (bad cycles %0d)",
                     execDup, origCnt, bad);
        end
        stallIf = 1'b0;
        tick(1);
        checks++;
        if (execDup !== 1'b1 || origCnt !== 4'd8) begin
            errors++;
            $display("[TB] FAIL stall_release: exec=%b orig=%0d required 1 8", execDup, origCnt);
        end
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        tick(2);
        checks++;
        if (execDup !== 1'b1 || dupCnt !== 4'd0) begin
            errors++;
            $display("[TB] FAIL stall_dup_hold: exec=%b dup=%0d required 1 0", execDup, dupCnt);
        end
    endtask

    task automatic test_ena_drop;
        int seen;
        startWindow();
        fetchVld = 1'b1;
        tick(2);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        tick(1);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        tick(2);
        dupVld = 1'b0;
        tick(2);
        ena = 1'b0;
        tick(1);
        checks++;
        if (execDup !== 1'b0 || qedCheck !== 1'b0 || qedDone !== 1'b0 ||
            origCnt !== 4'd0 || dupCnt !== 4'd0) begin
            errors++;
            $display("[TB] FAIL ena_drop_idle: exec=%b check=%b done=%b orig=%0d dup=%0d required 0 0 0 0 0",
                     execDup, qedCheck, qedDone, origCnt, dupCnt);
        end
        seen = 0;
        for (int i = 0; i < 5; i++) begin
            tick(1);
            if (qedCheck !== 1'b0) seen++;
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("[TB] FAIL ena_drop_no_check: pulses=%0d required 0", seen);
        end
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        tick(2);
        checks++;
        if (origCnt !== 4'd1 || execDup !== 1'b0) begin
            errors++;
            $display("[TB] FAIL ena_restart: orig=%0d exec=%b required 1 0", origCnt, execDup);
        end
    endtask

    task automatic test_async_reset;
        startWindow();
        fetchVld = 1'b1;
        tick(6);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        tick(1);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        tick(4);
        checks++;
        if (execDup !== 1'b1 || dupCnt !== 4'd4) begin
            errors++;
            $display("[TB] FAIL async_setup: exec=%b dup=%0d required 1 4", execDup, dupCnt);
        end
        #2;
        rstN = 1'b0;
        #1;
        checks++;
        if (execDup !== 1'b0 || dupCnt !== 4'd0 || origCnt !== 4'd0) begin
            errors++;
            $display("[TB] FAIL async_reset: exec=%b dup=%0d orig=%0d required 0 0 0",
                     execDup, dupCnt, origCnt);
        end
        #1;
        rstN = 1'b1;
    endtask

    task automatic test_dup_saturation;
        startWindow();
        fetchVld = 1'b1;
        tick(2);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        tick(1);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        tick(4);
        checks++;
        if (dupCnt !== 4'd2 || origCnt !== 4'd2 || execDup !== 1'b0) begin
            errors++;
            $display("[TB] FAIL dup_saturate: dup=%0d orig=%0d exec=%b required 2 2 0",
                     dupCnt, origCnt, execDup);
        end
    endtask

    initial begin
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        rstN = 1'b0;
        test_reset();
        test_full_window();
        test_force_dup();
        test_stall();
        test_ena_drop();
        test_async_reset();
        test_dup_saturation();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
